// File: rtl/riscv_alu.sv
// Single-cycle 32-bit RISC-V integer ALU with a registered result.
// Thirteen operations are selected by a 4-bit opcode; reserved opcodes yield zero.
module riscv_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      alu_op_i,
  input  logic [XLEN-1:0] alu_a_i,
  input  logic [XLEN-1:0] alu_b_i,
  output logic [XLEN-1:0] alu_p_o
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SLL  = 4'b0001,
    OP_SRL  = 4'b0010,
    OP_SRA  = 4'b0011,
    OP_DIVU = 4'b0100,
    OP_REMU = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_AND  = 4'b0111,
    OP_OR   = 4'b1000,
    OP_XOR  = 4'b1001,
    OP_SLTU = 4'b1010,
    OP_SLT  = 4'b1011,
    OP_MUL  = 4'b1100
  } alu_op_e;

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  shamt;
  logic            div_by_zero;
  logic [XLEN-1:0] result;

  // Only the low bits of B form the shift amount; the rest is ignored.
  assign shamt       = alu_b_i[SHW-1:0];
  assign div_by_zero = (alu_b_i == '0);

  always_comb begin
    result = '0;
    case (alu_op_e'(alu_op_i))
      OP_ADD:  result = alu_a_i + alu_b_i;
      OP_SLL:  result = alu_a_i << shamt;
      OP_SRL:  result = alu_a_i >> shamt;
      OP_SRA:  result = $signed(alu_a_i) >>> shamt;
      OP_DIVU: result = div_by_zero ? '1 : alu_a_i / alu_b_i;
      OP_REMU: result = div_by_zero ? alu_a_i : alu_a_i % alu_b_i;
      OP_SUB:  result = alu_a_i - alu_b_i;
      OP_AND:  result = alu_a_i & alu_b_i;
      OP_OR:   result = alu_a_i | alu_b_i;
      OP_XOR:  result = alu_a_i ^ alu_b_i;
      OP_SLTU: result = {{(XLEN-1){1'b0}}, (alu_a_i < alu_b_i)};
      OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(alu_a_i) < $signed(alu_b_i))};
      OP_MUL:  result = alu_a_i * alu_b_i;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_p_o <= '0;
    end else begin
      alu_p_o <= result;
    end
  end

endmodule

// File: tb/tb_riscv_alu.sv
// Scoreboard bench for riscv_alu: the driver queues expected results, a negedge monitor checks them.
// Directed cases come from known answers; random cases use an arithmetic reference model.
module tb_riscv_alu;

  logic        clk;
  logic        rst_n;
  logic [3:0]  alu_op_i;
  logic [31:0] alu_a_i;
  logic [31:0] alu_b_i;
  logic [31:0] alu_p_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  riscv_alu #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_op_i (alu_op_i),
    .alu_a_i  (alu_a_i),
    .alu_b_i  (alu_b_i),
    .alu_p_o  (alu_p_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference built from plain integer arithmetic: shifts as powers of two, SRA as floor division.
  function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint unsigned ua, ub, p2, r;
    longint sa, sb;
    int sh;
    ua = a;
    ub = b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    p2 = longint'(1) << sh;
    r  = 0;
    case (op)
      4'd0:  r = ua + ub;
      4'd1:  r = ua * p2;
      4'd2:  r = ua / p2;
      4'd3:  r = (sa >= 0) ? longint'(sa / longint'(p2))
                           : -((-sa + longint'(p2) - 1) / longint'(p2));
      4'd4:  r = (ub == 0) ? 64'hFFFF_FFFF : ua / ub;
      4'd5:  r = (ub == 0) ? ua : ua % ub;
      4'd6:  r = ua - ub;
      4'd7:  r = a & b;
      4'd8:  r = a | b;
      4'd9:  r = a ^ b;
      4'd10: r = (ua < ub) ? 1 : 0;
      4'd11: r = (sa < sb) ? 1 : 0;
      4'd12: r = ua * ub;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one op, then queue its expected result once the sampling edge has passed.
  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp, input string name);
    exp_t e;
    alu_op_i = op;
    alu_a_i  = a;
    alu_b_i  = b;
    @(posedge clk);
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_output(e.name, alu_p_o, e.exp);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;

    rst_n    = 1'b0;
    alu_op_i = 'x;
    alu_a_i  = 'x;
    alu_b_i  = 'x;
    #1;
    check_output("reset_async", alu_p_o, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_hold", alu_p_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(4'd0,  32'h1234_5678, 32'h8765_4321, 32'h9999_9999, "add");
    apply_stimulus(4'd6,  32'h1E,        32'h0A,        32'h14,        "sub");
    apply_stimulus(4'd12, 32'h1E,        32'h0A,        32'h12C,       "mul");
    apply_stimulus(4'd1,  32'h0C,        32'd2,         32'h30,        "sll");
    apply_stimulus(4'd2,  32'h0E,        32'd3,         32'h1,         "srl");
    apply_stimulus(4'd3,  32'hFFFF_FFF0, 32'd2,         32'hFFFF_FFFC, "sra");
    apply_stimulus(4'd1,  32'h1,         32'h20,        32'h1,         "sll_b32");
    apply_stimulus(4'd7,  32'hAABB_CCDD, 32'hFF00_FF00, 32'hAA00_CC00, "and");
    apply_stimulus(4'd8,  32'h00FF_00FF, 32'hF0F0_F0F0, 32'hF0FF_F0FF, "or");
    apply_stimulus(4'd9,  32'h0B,        32'h0B,        32'h0,         "xor");
    apply_stimulus(4'd10, 32'h0F,        32'h05,        32'h0,         "sltu");
    apply_stimulus(4'd11, 32'hFFFF_FFF0, 32'h0,         32'h1,         "slt_neg");
    apply_stimulus(4'd10, 32'hFFFF_FFF0, 32'h0,         32'h0,         "sltu_big");
    apply_stimulus(4'd11, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1,         "slt_min");
    apply_stimulus(4'd10, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0,         "sltu_min");
    apply_stimulus(4'd11, 32'h1234,      32'h1234,      32'h0,         "slt_eq");
    apply_stimulus(4'd10, 32'h1234,      32'h1234,      32'h0,         "sltu_eq");
    apply_stimulus(4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         "add_wrap");
    apply_stimulus(4'd6,  32'h0,         32'h1,         32'hFFFF_FFFF, "sub_wrap");
    apply_stimulus(4'd4,  32'h19,        32'd5,         32'h5,         "divu");
    apply_stimulus(4'd5,  32'h1A,        32'd5,         32'h1,         "remu");
    apply_stimulus(4'd4,  32'h7,         32'h0,         32'hFFFF_FFFF, "divu_zero");
    apply_stimulus(4'd5,  32'h7,         32'h0,         32'h7,         "remu_zero");
    apply_stimulus(4'd15, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0,         "reserved");

    // Reset between edges must drop the freshly registered result at once.
    alu_op_i = 4'd0;
    alu_a_i  = 32'h5;
    alu_b_i  = 32'h6;
    @(posedge clk);
    #1;
    check_output("pre_reset", alu_p_o, 32'hB);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("mid_reset", alu_p_o, 32'h0);
    @(posedge clk);
    #1;
    check_output("mid_reset_hold", alu_p_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(4'd0, 32'h10, 32'h20, 32'h30, "post_reset");

    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'($urandom_range(0, 40));
        2: a = 32'h8000_0000;
        default: ;
      endcase
      apply_stimulus(op, a, b, ref_model(op, a, b), $sformatf("rand_op%0d", op));
    end

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
